// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus an iterative shift-add
// multiplier, with valid/ready handshakes on operands and result.
module alu_mc #(
  parameter int W = 16,
  localparam int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [3:0]   flags
);

  // state | meaning
  // IDLE  | waiting for an operation
  // MUL   | iterating the shift-add multiplier, one multiplier bit per cycle
  // DONE  | result valid, held until out_ready
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_NEG = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOR = 4'h7;
  localparam logic [3:0] OP_SLL = 4'h8, OP_SRL = 4'h9, OP_ROL = 4'hA, OP_SWP = 4'hB;
  localparam logic [W-1:0] W_VAL = W[W-1:0];
  localparam logic [SHW:0] W_SH  = W[SHW:0];
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_t         state, state_nxt;
  logic           accept;
  logic [W-1:0]   mcand, hi, lo;
  logic [SHW-1:0] cnt;

  logic [W:0]     add_s, sub_s, mul_sum;
  logic [W-1:0]   neg_s, sll_m1, srl_m1, rol_s, swp_s, mul_lo_n, mul_hi_n;
  logic [SHW:0]   shm1, rot_m;
  logic           b_ge_w, b_gt_w, shift_c_ok;
  logic [W-1:0]   y_n;
  logic           c_n, v_n;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:   if (cnt == '0) state_nxt = S_DONE;
      S_DONE: begin
        if (accept)         state_nxt = (op == OP_MUL) ? S_MUL : S_DONE;
        else if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    out_valid = (state == S_DONE);
  end

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} - {1'b0, b};
  assign neg_s = '0 - a;

  // Shifting by b-1 exposes the last bit shifted out at the edge of the word.
  assign shm1       = b[SHW:0] - {{SHW{1'b0}}, 1'b1};
  assign sll_m1     = a << shm1;
  assign srl_m1     = a >> shm1;
  assign b_ge_w     = (b >= W_VAL);
  assign b_gt_w     = (b > W_VAL);
  assign shift_c_ok = (b != '0) & ~b_gt_w;

  assign rot_m = ({1'b0, b[SHW-1:0]} >= W_SH) ? {1'b0, b[SHW-1:0]} - W_SH : {1'b0, b[SHW-1:0]};
  assign rol_s = (a << rot_m) | (a >> (W_SH - rot_m));

  always_comb begin
    swp_s = '0;
    for (int i = 0; i < W / 8; i++) begin
      swp_s[8*i +: 4]     = a[8*i + 4 +: 4];
      swp_s[8*i + 4 +: 4] = a[8*i +: 4];
    end
  end

  always_comb begin
    y_n = '0;
    c_n = 1'b0;
    v_n = 1'b0;
    case (op)
      OP_ADD: begin
        y_n = add_s[W-1:0];
        c_n = add_s[W];
        v_n = (a[W-1] == b[W-1]) & (add_s[W-1] != a[W-1]);
      end
      OP_SUB: begin
        y_n = sub_s[W-1:0];
        c_n = sub_s[W];
        v_n = (a[W-1] != b[W-1]) & (sub_s[W-1] != a[W-1]);
      end
      OP_NEG: begin
        y_n = neg_s;
        v_n = (a == MIN_NEG);
      end
      OP_AND: y_n = a & b;
      OP_OR:  y_n = a | b;
      OP_XOR: y_n = a ^ b;
      OP_NOR: y_n = ~(a | b);
      OP_SLL: begin
        y_n = b_ge_w ? '0 : (a << b[SHW-1:0]);
        c_n = shift_c_ok & sll_m1[W-1];
      end
      OP_SRL: begin
        y_n = b_ge_w ? '0 : (a >> b[SHW-1:0]);
        c_n = shift_c_ok & srl_m1[0];
      end
      OP_ROL:  y_n = rol_s;
      OP_SWP:  y_n = swp_s;
      default: y_n = '0;
    endcase
  end

  // Right-shifting add-shift multiplier: {hi,lo} holds the partial product,
  // lo starts as the multiplier and is consumed LSB first.
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  assign mul_lo_n = {mul_sum[0], lo[W-1:1]};
  assign mul_hi_n = mul_sum[W:1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      y     <= '0;
      flags <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        mcand <= a;
        lo    <= b;
        hi    <= '0;
        cnt   <= SHW'(W - 1);
      end else begin
        y     <= y_n;
        flags <= {(y_n == '0), y_n[W-1], c_n, v_n};
      end
    end else if (state == S_MUL) begin
      hi  <= mul_hi_n;
      lo  <= mul_lo_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        y     <= mul_lo_n;
        flags <= {(mul_lo_n == '0), mul_lo_n[W-1], (mul_hi_n != '0), 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (W=16): directed cases, backpressure, reset
// during multiply, and a randomized stream against an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  alu_mc #(.W(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference computed from the operation definitions with plain integer arithmetic.
  function automatic void model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] z,
                                output logic [15:0] r, output logic [3:0] f);
    int unsigned ux, uz, k;
    longint      p;
    int          sx, sz, sr;
    logic        c, v;
    ux = x; uz = z;
    sx = int'($signed(x)); sz = int'($signed(z));
    c = 1'b0; v = 1'b0; r = 16'h0;
    case (o)
      4'h0: begin
        p = longint'(ux) + longint'(uz); r = p[15:0]; c = p[16];
        sr = sx + sz; v = (sr > 32767) || (sr < -32768);
      end
      4'h1: begin
        r = 16'(ux - uz); c = (ux < uz);
        sr = sx - sz; v = (sr > 32767) || (sr < -32768);
      end
      4'h2: begin
        p = longint'(ux) * longint'(uz); r = p[15:0]; c = (p[31:16] != 0);
      end
      4'h3: begin
        sr = -sx; r = sr[15:0]; v = (sr > 32767);
      end
      4'h4: r = x & z;
      4'h5: r = x | z;
      4'h6: r = x ^ z;
      4'h7: r = ~(x | z);
      4'h8: begin
        r = (uz >= 16) ? 16'h0 : 16'(ux << uz);
        c = (uz >= 1 && uz <= 16) ? (((ux >> (16 - uz)) & 1) != 0) : 1'b0;
      end
      4'h9: begin
        r = (uz >= 16) ? 16'h0 : 16'(ux >> uz);
        c = (uz >= 1 && uz <= 16) ? (((ux >> (uz - 1)) & 1) != 0) : 1'b0;
      end
      4'hA: begin
        k = uz % 16;
        r = 16'((ux << k) | (ux >> (16 - k)));
      end
      4'hB: begin
        for (int i = 0; i < 2; i++) begin
          r[8*i +: 4]     = x[8*i + 4 +: 4];
          r[8*i + 4 +: 4] = x[8*i +: 4];
        end
      end
      default: r = 16'h0;
    endcase
    f = {(r == 16'h0), r[15], c, v};
  endfunction

  // Issue one op with out_ready held high; check result, flags, latency and in_ready-low cycles.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] x,
                        input logic [15:0] z, input logic [15:0] ey, input logic [3:0] ef);
    int g, n, lowc, elat;
    elat = (o == 4'h2) ? 17 : 1;
    op = o; a = x; b = z; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    check({tag, "_accept_timeout"}, 32'(g < 50), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
    n = 1; lowc = 0;
    while (!out_valid && n < 60) begin
      if (!in_ready) lowc++;
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(elat));
    check({tag, "_inready_low"}, 32'(lowc), 32'(elat - 1));
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_flags"}, 32'(flags), 32'(ef));
  endtask

  logic [15:0] ry, ra, rb;
  logic [3:0]  rf, rop;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; op = 4'h0; a = 16'h0; b = 16'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf", 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    run_op("sub_borrow", 4'h1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110);
    run_op("neg_min", 4'h3, 16'h8000, 16'h0000, 16'h8000, 4'b0101);
    run_op("mul_hi", 4'h2, 16'h0100, 16'h0101, 16'h0100, 4'b0010);
    run_op("sll_1", 4'h8, 16'h8001, 16'h0001, 16'h0002, 4'b0010);
    run_op("sll_w", 4'h8, 16'h8001, 16'h0010, 16'h0000, 4'b1010);
    run_op("sll_big", 4'h8, 16'h8001, 16'h0100, 16'h0000, 4'b1000);
    run_op("srl_gt_w", 4'h9, 16'hFFFF, 16'h0014, 16'h0000, 4'b1000);
    run_op("srl_0", 4'h9, 16'h8001, 16'h0000, 16'h8001, 4'b0100);
    run_op("rol_17", 4'hA, 16'h8001, 16'h0011, 16'h0003, 4'b0000);
    run_op("swp", 4'hB, 16'h12AB, 16'h0000, 16'h21BA, 4'b0000);
    run_op("reserved", 4'hD, 16'h1234, 16'h5678, 16'h0000, 4'b1000);

    // Backpressure: result held while out_ready low, then retire+accept in one cycle.
    @(posedge clk); #1;
    out_ready = 1'b0;
    op = 4'h0; a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h0010; b = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_y", 32'(y), 32'h3);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_y", 32'(y), 32'h30);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Reset while the multiplier is iterating.
    op = 4'h2; a = 16'h0003; b = 16'h0005; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mulrst_busy", 32'(in_ready), 32'd0);
    resetn = 1'b0;
    #2;
    check("mulrst_out_valid", 32'(out_valid), 32'd0);
    check("mulrst_y", 32'(y), 32'd0);
    check("mulrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      check("mulrst_no_result", 32'(out_valid), 32'd0);
    end
    run_op("after_rst_add", 4'h0, 16'h1111, 16'h2222, 16'h3333, 4'b0000);

    // Randomized stream against the reference model.
    for (int i = 0; i < 300; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ((rop >= 4'h8 && rop <= 4'hA) && ($urandom_range(0, 3) != 0))
        rb = 16'($urandom_range(0, 20));
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      model(rop, ra, rb, ry, rf);
      run_op("rand", rop, ra, rb, ry, rf);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
